sha3_axis_absorber: RTL
=======================

Name: sha3_axis_absorber

Overview:
- Successor to the fixed-width 1600-bit AXI-Stream input register of the SHA-3 core.
- Collects AXI-Stream beats of parametrisable width into rate-sized Keccak blocks. Applies byte-exact SHA-3 pad10*1 with domain suffix 0x06 on TLAST. Supports multi-block messages.
- Hands each 1600-bit block to the permutation core over a valid/ready handshake, with full backpressure on the input stream.

Parameters:
- DATA_WIDTH, 64, stream data width in bits. Legal values: 8, 16, 32, 64, so every rate is a whole number of beats.
- BPB, DATA_WIDTH/8, bytes per beat (derived, not overridable).

Ports:
- ACLK  input  1  clock; single clock domain.
- ARESET  input  1  reset, asynchronous, active-high.
- S_TVALID  input  1  input beat valid.
- S_TREADY  output  1  input beat accepted when high with S_TVALID.
- S_TDATA  input  DATA_WIDTH  message bytes; byte k occupies bits [8k+7:8k].
- S_TKEEP  input  BPB  byte enables; contiguous from bit 0; all ones on non-last beats.
- S_TLAST  input  1  final beat of message.
- S_TID  input  2  mode, sampled on first beat of a message: 0=SHA3-224 (rate 144 B), 1=SHA3-256 (136 B), 2=SHA3-384 (104 B), 3=SHA3-512 (72 B).
- BLK_VALID  output  1  block available.
- BLK_READY  input  1  permutation core accepts block.
- BLK_DATA  output  1600  block; beat i at bits [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]; capacity bytes always zero.
- BLK_LAST  output  1  block is the final (padded) block of the message.
- BLK_MODE  output  2  latched mode of the message.

Behaviour:
- Reset (async assert, sync deassert):
  - state=FILL, beat counter cnt=0, buffer all zero, pad_pending=0.
  - BLK_VALID=0, BLK_LAST=0, BLK_MODE=0.
  - S_TREADY=0 while ARESET is high.
- Derived values: RATE_B = rate bytes of the latched mode; BEATS = RATE_B/BPB.
- States: FILL, OUT, PAD.
- FILL:
  - S_TREADY=1.
  - On a handshake, write the beat at index cnt. Bytes with TKEEP=0 are written as 0.
  - First beat of a message (cnt=0, no message in progress) latches S_TID into mode. S_TID is ignored on all later beats.
- Non-last beat: cnt+1. If cnt==BEATS-1, go to OUT with BLK_LAST=0 and set cnt=0.
- Last beat: compute p = cnt*BPB + popcount(S_TKEEP).
  - If p<RATE_B: byte p |= 0x06, byte RATE_B-1 |= 0x80. Go to OUT with BLK_LAST=1.
  - If p==RATE_B-1, the two pad bytes coincide and the result is 0x86.
  - If p==RATE_B (message ends exactly on a block boundary): go to OUT with BLK_LAST=0 and set pad_pending=1.
  - S_TKEEP=0 on a last beat is legal and means no new bytes.
- OUT:
  - S_TREADY=0. BLK_VALID=1.
  - BLK_DATA, BLK_LAST and BLK_MODE are held stable until BLK_READY.
  - On handshake: clear the buffer.
  - If pad_pending, go to PAD. Otherwise go to FILL with cnt=0; a last block also ends the message.
- PAD (1 cycle):
  - Buffer byte 0 = 0x06, byte RATE_B-1 = 0x80.
  - Clear pad_pending and go to OUT with BLK_LAST=1.
- Latency and throughput:
  - BLK_VALID rises the cycle after the beat that completes a block.
  - S_TREADY is back at 1 the cycle after the block handshake.
  - One bubble per block; a boundary-aligned message costs 2 extra cycles.
- Illegal TKEEP values (non-contiguous, or not all ones on a non-last beat) give undefined data but must not hang the FSM.
- ARESET mid-message or mid-OUT: the block is dropped, BLK_VALID falls immediately, and the next message starts at beat 0 with a zeroed buffer.

Test Plan:
- DATA_WIDTH=64, TID=1, single beat, TLAST=1, TKEEP=0x00 -> one block, byte0=0x06, byte135=0x80, all other bytes 0, BLK_LAST=1, BLK_MODE=1.
- TID=1, TDATA=0x636261 ("abc"), TKEEP=0x07, TLAST=1 -> bytes 0..3 = 61 62 63 06, byte135=0x80, BLK_LAST=1; BLK_VALID high exactly 1 cycle after the beat.
- TID=3, 9 full beats (72 B), TLAST on beat 9 -> block 1 carries the data with BLK_LAST=0; then block 2 = byte0 0x06, byte71 0x80, BLK_LAST=1; no beats accepted between the two blocks.
- TID=3, 71-byte message (beat 9 TKEEP=0x7F) -> single block, byte71=0x86, BLK_LAST=1.
- Hold BLK_READY=0 for 10 cycles with S_TVALID=1 -> S_TREADY=0 throughout, BLK_DATA stable, and the next beat is accepted 1 cycle after BLK_READY=1.
- Assert ARESET after 5 beats of a TID=0 message, then send the "abc" test with TID=2 -> BLK_VALID=0 during reset; block has bytes 0..3 = 61 62 63 06, byte103=0x80, no residue from earlier data, BLK_MODE=2.

Source files
------------

// File: rtl/sha3_axis_absorber.sv
// Purpose: packs AXI-Stream beats into rate-sized Keccak blocks with SHA-3 pad10*1 (suffix 0x06).
// Latency: BLK_VALID rises the cycle after the completing beat; PAD adds one cycle for aligned messages.
// Backpressure: S_TREADY is low while a block waits in OUT or is being padded; held until BLK_READY.
module sha3_axis_absorber #(
    parameter  int DATA_WIDTH = 64,
    localparam int BPB        = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  S_TVALID,
    output logic                  S_TREADY,
    input  logic [DATA_WIDTH-1:0] S_TDATA,
    input  logic [BPB-1:0]        S_TKEEP,
    input  logic                  S_TLAST,
    input  logic [1:0]            S_TID,
    output logic                  BLK_VALID,
    input  logic                  BLK_READY,
    output logic [1599:0]         BLK_DATA,
    output logic                  BLK_LAST,
    output logic [1:0]            BLK_MODE
);

    localparam int NBEAT_MAX = 1600 / DATA_WIDTH;

    typedef enum logic [1:0] {ST_FILL, ST_OUT, ST_PAD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1599:0] buf_q, buf_d;
    logic          pad_q, pad_d;
    logic [1:0]    mode_q, mode_d;
    logic          last_q, last_d;
    logic          in_msg_q, in_msg_d;

    logic [1:0]            eff_mode;
    logic [7:0]            rate_f;
    logic [7:0]            rate_p;
    logic [7:0]            beats_m1;
    logic [7:0]            kcnt;
    logic [7:0]            p;
    logic [DATA_WIDTH-1:0] wdat;

    // Rate in bytes for each SHA-3 variant.
    function automatic logic [7:0] rate_of(input logic [1:0] m);
        case (m)
            2'd0:    rate_of = 8'd144;
            2'd1:    rate_of = 8'd136;
            2'd2:    rate_of = 8'd104;
            default: rate_of = 8'd72;
        endcase
    endfunction

    // Beat decode: mode in force, masked write data and the pad position.
    always_comb begin
        eff_mode = in_msg_q ? mode_q : S_TID;
        rate_f   = rate_of(eff_mode);
        rate_p   = rate_of(mode_q);
        beats_m1 = (rate_f / 8'(BPB)) - 8'd1;
        kcnt     = '0;
        wdat     = '0;
        for (int k = 0; k < BPB; k++) begin
            kcnt = kcnt + {7'd0, S_TKEEP[k]};
            wdat[8*k +: 8] = S_TKEEP[k] ? S_TDATA[8*k +: 8] : 8'h00;
        end
        p = cnt_q * 8'(BPB) + kcnt;
    end

    // Next-state, buffer update and padding.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        pad_d    = pad_q;
        mode_d   = mode_q;
        last_d   = last_q;
        in_msg_d = in_msg_q;
        case (state_q)
            ST_FILL: begin
                if (S_TVALID) begin
                    in_msg_d = 1'b1;
                    mode_d   = eff_mode;
                    for (int i = 0; i < NBEAT_MAX; i++) begin
                        if (cnt_q == 8'(i)) buf_d[i*DATA_WIDTH +: DATA_WIDTH] = wdat;
                    end
                    if (!S_TLAST) begin
                        if (cnt_q >= beats_m1) begin
                            state_d = ST_OUT;
                            last_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_OUT;
                        cnt_d   = '0;
                        if (p < rate_f) begin
                            // Suffix and final pad bit; they merge into 0x86 when adjacent.
                            for (int b = 0; b < 200; b++) begin
                                if (8'(b) == p)             buf_d[8*b +: 8] = buf_d[8*b +: 8] | 8'h06;
                                if (8'(b) == rate_f - 8'd1) buf_d[8*b +: 8] = buf_d[8*b +: 8] | 8'h80;
                            end
                            last_d = 1'b1;
                        end else begin
                            // Message filled the block exactly: padding goes in a block of its own.
                            last_d = 1'b0;
                            pad_d  = 1'b1;
                        end
                    end
                end
            end
            ST_OUT: begin
                if (BLK_READY) begin
                    buf_d = '0;
                    if (pad_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        if (last_q) in_msg_d = 1'b0;
                    end
                end
            end
            ST_PAD: begin
                buf_d = '0;
                buf_d[7:0] = 8'h06;
                for (int b = 0; b < 200; b++) begin
                    if (8'(b) == rate_p - 8'd1) buf_d[8*b +: 8] = buf_d[8*b +: 8] | 8'h80;
                end
                pad_d   = 1'b0;
                last_d  = 1'b1;
                state_d = ST_OUT;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State and datapath registers; reset drops any in-flight block.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= ST_FILL;
            cnt_q    <= '0;
            buf_q    <= '0;
            pad_q    <= 1'b0;
            mode_q   <= 2'd0;
            last_q   <= 1'b0;
            in_msg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            pad_q    <= pad_d;
            mode_q   <= mode_d;
            last_q   <= last_d;
            in_msg_q <= in_msg_d;
        end
    end

    assign S_TREADY  = (state_q == ST_FILL) && !ARESET;
    assign BLK_VALID = (state_q == ST_OUT);
    assign BLK_DATA  = buf_q;
    assign BLK_LAST  = last_q;
    assign BLK_MODE  = mode_q;

endmodule
